// File: rtl/onchip_dpram_arb_if.sv
// One Avalon-MM slave port of onchip_dpram_arb; the RAM has two of these (s1, s2).
// Handshake: a request (chipselect & (read | write) & clken) is accepted in a cycle where
// waitrequest is low; a stalled request must be held unchanged by the master until accepted.
interface onchip_dpram_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    logic                      clken;
    logic                      chipselect;
    logic                      read;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH/8-1:0]   byteenable;
    logic [DATA_WIDTH-1:0]     writedata;
    logic                      waitrequest;
    logic [DATA_WIDTH-1:0]     readdata;
    logic                      readdatavalid;

    modport master (
        output clken, chipselect, read, write, address, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  clken, chipselect, read, write, address, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_dpram_arb.sv
// True dual-port RAM with pipelined reads, same-address write arbitration with
// rotating priority, and mixed-port read-during-write forwarding of new data.
module onchip_dpram_arb #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 11,
    parameter int    DEPTH      = 2048,
    parameter int    OUTPUT_REG = 0,
    parameter string INIT_FILE  = "onchip_dpram_arb.hex"
) (
    input logic               clk,
    input logic               reset,
    input logic               reset_req,
    onchip_dpram_arb_if.slave s1,
    onchip_dpram_arb_if.slave s2
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            req, is_wr, in_rng, wait_p, acc;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [NB-1:0]         be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic                  collision;
    logic                  prio_q, prio_d;
    logic [1:0]            rv_q, rv_d;
    logic [DATA_WIDTH-1:0] rd_q [2];
    logic [DATA_WIDTH-1:0] rd_d [2];
    logic [1:0]            out_v;
    logic [DATA_WIDTH-1:0] out_d [2];

    // Preloading from INIT_FILE is left to the device memory-initialisation flow;
    // the RTL array itself starts undefined.
    if (INIT_FILE == "") begin : g_uninit
    end

    assign req[0]   = s1.chipselect & (s1.read | s1.write) & s1.clken;
    assign req[1]   = s2.chipselect & (s2.read | s2.write) & s2.clken;
    assign is_wr[0] = s1.write;
    assign is_wr[1] = s2.write;
    assign addr[0]  = s1.address;
    assign addr[1]  = s2.address;
    assign be[0]    = s1.byteenable;
    assign be[1]    = s2.byteenable;
    assign wdata[0] = s1.writedata;
    assign wdata[1] = s2.writedata;
    assign in_rng[0] = {1'b0, addr[0]} < DEPTH_L;
    assign in_rng[1] = {1'b0, addr[1]} < DEPTH_L;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q  <= 1'b0;
            rv_q    <= '0;
            rd_q[0] <= '0;
            rd_q[1] <= '0;
        end else begin
            prio_q  <= prio_d;
            rv_q    <= rv_d;
            rd_q[0] <= rd_d[0];
            rd_q[1] <= rd_d[1];
        end
    end

    // The collision winner drops priority, so a loser is never stalled twice in a row.
    always_comb begin
        collision = req[0] & req[1] & is_wr[0] & is_wr[1] & (addr[0] == addr[1]);
        prio_d    = prio_q ^ (collision & ~reset_req);
    end

    always_comb begin
        wait_p[0] = reset_req | (collision & prio_q);
        wait_p[1] = reset_req | (collision & ~prio_q);
        acc       = req & ~wait_p;
    end

    // Read capture: old word, with the other port's same-cycle write lanes merged in.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rv_d[p] = acc[p] & ~is_wr[p];
            rd_d[p] = rd_q[p];
            if (rv_d[p]) begin
                rd_d[p] = in_rng[p] ? mem[addr[p]] : '0;
                if (in_rng[p] && acc[1-p] && is_wr[1-p] && (addr[1-p] == addr[p])) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[1-p][b]) rd_d[p][8*b +: 8] = wdata[1-p][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (acc[p] && is_wr[p] && in_rng[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[p][b]) mem[addr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
                end
            end
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic [1:0]            ov_q;
        logic [DATA_WIDTH-1:0] od_q [2];
        logic [DATA_WIDTH-1:0] od_d [2];

        always_comb begin
            for (int p = 0; p < 2; p++) begin
                od_d[p] = rv_q[p] ? rd_q[p] : od_q[p];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ov_q    <= '0;
                od_q[0] <= '0;
                od_q[1] <= '0;
            end else begin
                ov_q    <= rv_q;
                od_q[0] <= od_d[0];
                od_q[1] <= od_d[1];
            end
        end

        assign out_v    = ov_q;
        assign out_d[0] = od_q[0];
        assign out_d[1] = od_q[1];
    end else begin : g_noreg
        assign out_v    = rv_q;
        assign out_d[0] = rd_q[0];
        assign out_d[1] = rd_q[1];
    end

    assign s1.waitrequest   = wait_p[0];
    assign s2.waitrequest   = wait_p[1];
    assign s1.readdatavalid = out_v[0];
    assign s2.readdatavalid = out_v[1];
    assign s1.readdata      = out_d[0];
    assign s2.readdata      = out_d[1];
endmodule

// File: tb/tb_onchip_dpram_arb.sv
// Bench for onchip_dpram_arb: two instances (read latency 1 and 2) driven by identical
// stimulus, checked every cycle against a behavioural model plus literal expectations.
module tb_onchip_dpram_arb;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_req = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onchip_dpram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
    onchip_dpram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
    onchip_dpram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
    onchip_dpram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

    assign b1.clken = a1.clken;           assign b2.clken = a2.clken;
    assign b1.chipselect = a1.chipselect; assign b2.chipselect = a2.chipselect;
    assign b1.read = a1.read;             assign b2.read = a2.read;
    assign b1.write = a1.write;           assign b2.write = a2.write;
    assign b1.address = a1.address;       assign b2.address = a2.address;
    assign b1.byteenable = a1.byteenable; assign b2.byteenable = a2.byteenable;
    assign b1.writedata = a1.writedata;   assign b2.writedata = a2.writedata;

    onchip_dpram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUTPUT_REG(0),
                       .INIT_FILE("")) dut0 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .s1(a1), .s2(a2));

    onchip_dpram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUTPUT_REG(1),
                       .INIT_FILE("")) dut1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .s1(b1), .s2(b2));

    // Channels: 0 = dut0.s1, 1 = dut0.s2, 2 = dut1.s1, 3 = dut1.s2
    logic [3:0]    dv, dwt;
    logic [DW-1:0] dd [4];
    assign dv  = {b2.readdatavalid, b1.readdatavalid, a2.readdatavalid, a1.readdatavalid};
    assign dwt = {b2.waitrequest, b1.waitrequest, a2.waitrequest, a1.waitrequest};
    assign dd[0] = a1.readdata;
    assign dd[1] = a2.readdata;
    assign dd[2] = b1.readdata;
    assign dd[3] = b2.readdata;

    // ---------------- model ----------------
    typedef struct {
        int            ch;
        int            due;
        logic [DW-1:0] data;
    } ev_t;

    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] last_d [4] = '{default: '0};
    ev_t           exp_q[$];
    ev_t           keep_q[$];
    bit            s2_turn = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] peek(input logic [AW-1:0] ra, input bit hit,
                                           input logic [AW-1:0] wa, input logic [3:0] wbe,
                                           input logic [DW-1:0] wd);
        logic [DW-1:0] r;
        if (int'(ra) >= DEPTH) return '0;
        r = mdl_mem[ra];
        if (hit && wa == ra)
            for (int b = 0; b < 4; b++) if (wbe[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic mdl_write(input logic [AW-1:0] wa, input logic [3:0] wbe, input logic [DW-1:0] wd);
        if (int'(wa) < DEPTH)
            for (int b = 0; b < 4; b++) if (wbe[b]) mdl_mem[wa][8*b +: 8] = wd[8*b +: 8];
    endtask

    always @(negedge clk) begin
        logic [3:0]    ev;
        logic [DW-1:0] ed [4];
        bit            r1, r2, coll, w1, w2, x1, x2;
        logic [DW-1:0] v;
        if (!reset) begin
            ev = '0;
            for (int i = 0; i < 4; i++) ed[i] = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].due == cyc) begin
                    ev[exp_q[i].ch] = 1'b1;
                    ed[exp_q[i].ch] = exp_q[i].data;
                end
            end
            keep_q = {};
            foreach (exp_q[i]) if (exp_q[i].due > cyc) keep_q.push_back(exp_q[i]);
            exp_q = keep_q;
            for (int ch = 0; ch < 4; ch++) begin
                chk($sformatf("valid ch%0d cyc%0d", ch, cyc), 32'(dv[ch]), 32'(ev[ch]));
                if (ev[ch]) last_d[ch] = ed[ch];
                chk($sformatf("rdata ch%0d cyc%0d", ch, cyc), dd[ch], last_d[ch]);
            end

            r1   = a1.chipselect & (a1.read | a1.write) & a1.clken;
            r2   = a2.chipselect & (a2.read | a2.write) & a2.clken;
            coll = r1 && r2 && a1.write && a2.write && (a1.address == a2.address);
            w1   = reset_req || (coll && s2_turn);
            w2   = reset_req || (coll && !s2_turn);
            chk($sformatf("wait s1 dut0 cyc%0d", cyc), 32'(dwt[0]), 32'(w1));
            chk($sformatf("wait s2 dut0 cyc%0d", cyc), 32'(dwt[1]), 32'(w2));
            chk($sformatf("wait s1 dut1 cyc%0d", cyc), 32'(dwt[2]), 32'(w1));
            chk($sformatf("wait s2 dut1 cyc%0d", cyc), 32'(dwt[3]), 32'(w2));
            x1 = r1 && !w1;
            x2 = r2 && !w2;
            if (x1 && !a1.write) begin
                v = peek(a1.address, x2 && a2.write, a2.address, a2.byteenable, a2.writedata);
                exp_q.push_back('{ch: 0, due: cyc + 1, data: v});
                exp_q.push_back('{ch: 2, due: cyc + 2, data: v});
            end
            if (x2 && !a2.write) begin
                v = peek(a2.address, x1 && a1.write, a1.address, a1.byteenable, a1.writedata);
                exp_q.push_back('{ch: 1, due: cyc + 1, data: v});
                exp_q.push_back('{ch: 3, due: cyc + 2, data: v});
            end
            if (x1 && a1.write) mdl_write(a1.address, a1.byteenable, a1.writedata);
            if (x2 && a2.write) mdl_write(a2.address, a2.byteenable, a2.writedata);
            if (coll && !reset_req) s2_turn = !s2_turn;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input int p, input bit rd, input bit wr, input logic [AW-1:0] ad,
                         input logic [3:0] be, input logic [DW-1:0] d);
        if (p == 1) begin
            a1.chipselect = rd | wr; a1.read = rd; a1.write = wr;
            a1.address = ad; a1.byteenable = be; a1.writedata = d;
        end else begin
            a2.chipselect = rd | wr; a2.read = rd; a2.write = wr;
            a2.address = ad; a2.byteenable = be; a2.writedata = d;
        end
    endtask

    task automatic idle();
        set_p(1, 1'b0, 1'b0, '0, '0, '0);
        set_p(2, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input int p, input logic [AW-1:0] ad, input logic [3:0] be, input logic [DW-1:0] d);
        set_p(p, 1'b0, 1'b1, ad, be, d);
        step();
        idle();
    endtask

    // Called one cycle after the read was accepted: dut0 data now, dut1 one cycle later.
    task automatic rd_chk(input int p, input logic [DW-1:0] exp, input string nm);
        if (p == 1) begin
            chk({nm, " dut0 s1 valid"}, 32'(a1.readdatavalid), 32'd1);
            chk({nm, " dut0 s1 data"}, a1.readdata, exp);
        end else begin
            chk({nm, " dut0 s2 valid"}, 32'(a2.readdatavalid), 32'd1);
            chk({nm, " dut0 s2 data"}, a2.readdata, exp);
        end
        step();
        if (p == 1) begin
            chk({nm, " dut1 s1 valid"}, 32'(b1.readdatavalid), 32'd1);
            chk({nm, " dut1 s1 data"}, b1.readdata, exp);
        end else begin
            chk({nm, " dut1 s2 valid"}, 32'(b2.readdatavalid), 32'd1);
            chk({nm, " dut1 s2 data"}, b2.readdata, exp);
        end
    endtask

    task automatic rd_lit(input int p, input logic [AW-1:0] ad, input logic [DW-1:0] exp, input string nm);
        set_p(p, 1'b1, 1'b0, ad, '0, '0);
        step();
        idle();
        rd_chk(p, exp, nm);
    endtask

    task automatic chk_waits(input string nm, input bit e1, input bit e2);
        chk({nm, " wait s1 dut0"}, 32'(a1.waitrequest), 32'(e1));
        chk({nm, " wait s2 dut0"}, 32'(a2.waitrequest), 32'(e2));
        chk({nm, " wait s1 dut1"}, 32'(b1.waitrequest), 32'(e1));
        chk({nm, " wait s2 dut1"}, 32'(b2.waitrequest), 32'(e2));
    endtask

    initial begin
        a1.clken = 1'b1;
        a2.clken = 1'b1;
        idle();
        repeat (2) step();
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("reset valid ch%0d", ch), 32'(dv[ch]), 32'd0);
            chk($sformatf("reset rdata ch%0d", ch), dd[ch], 32'd0);
        end
        reset = 1'b0;
        step();

        // Same-address write collision, then the rotated repeat
        set_p(1, 1'b0, 1'b1, 10'd3, 4'hF, 32'h11);
        set_p(2, 1'b0, 1'b1, 10'd3, 4'hF, 32'h22);
        #1 chk_waits("coll1", 1'b0, 1'b1);
        step();
        set_p(1, 1'b0, 1'b0, '0, '0, '0);
        #1 chk_waits("coll1 retry", 1'b0, 1'b0);
        step();
        idle();
        rd_lit(1, 10'd3, 32'h22, "coll1 read @3");

        set_p(1, 1'b0, 1'b1, 10'd3, 4'hF, 32'h33);
        set_p(2, 1'b0, 1'b1, 10'd3, 4'hF, 32'h44);
        #1 chk_waits("coll2", 1'b1, 1'b0);
        step();
        set_p(2, 1'b0, 1'b0, '0, '0, '0);
        #1 chk_waits("coll2 retry", 1'b0, 1'b0);
        step();
        idle();
        rd_lit(2, 10'd3, 32'h33, "coll2 read @3");

        // Plain write then cross-port read
        wr(1, 10'd5, 4'hF, 32'hDEADBEEF);
        rd_lit(2, 10'd5, 32'hDEADBEEF, "read @5");

        // Partial byte-enable write
        wr(1, 10'd9, 4'hF, 32'h12345678);
        wr(1, 10'd9, 4'b0011, 32'hAAAAAAAA);
        rd_lit(1, 10'd9, 32'h1234AAAA, "be0011 @9");

        // Mixed-port read-during-write, full word and lane-merged
        wr(2, 10'd7, 4'hF, 32'h01020304);
        set_p(1, 1'b0, 1'b1, 10'd7, 4'hF, 32'hCAFEF00D);
        set_p(2, 1'b1, 1'b0, 10'd7, '0, '0);
        step();
        idle();
        rd_chk(2, 32'hCAFEF00D, "rdw full @7");
        set_p(2, 1'b0, 1'b1, 10'd7, 4'b1100, 32'h55660000);
        set_p(1, 1'b1, 1'b0, 10'd7, '0, '0);
        step();
        idle();
        rd_chk(1, 32'h5566F00D, "rdw merge @7");

        for (int i = 0; i < 4; i++) wr(2, AW'(i), 4'hF, 32'hA0A0A000 + i);

        // reset_req blocks both ports and leaves memory alone
        reset_req = 1'b1;
        set_p(1, 1'b0, 1'b1, 10'd0, 4'hF, 32'hFFFFFFFF);
        set_p(2, 1'b0, 1'b1, 10'd1, 4'hF, 32'hFFFFFFFF);
        #1 chk_waits("reset_req", 1'b1, 1'b1);
        step();
        reset_req = 1'b0;
        idle();
        rd_lit(1, 10'd0, 32'hA0A0A000, "after reset_req @0");
        rd_lit(2, 10'd1, 32'hA0A0A001, "after reset_req @1");

        // Accepted read still completes under reset_req
        set_p(1, 1'b1, 1'b0, 10'd2, '0, '0);
        step();
        idle();
        reset_req = 1'b1;
        rd_chk(1, 32'hA0A0A002, "drain under reset_req @2");
        reset_req = 1'b0;

        // Out-of-range addresses
        wr(1, 10'd1000, 4'hF, 32'h77777777);
        rd_lit(2, 10'd1000, 32'h0, "oor read @1000");
        rd_lit(1, 10'd1023, 32'h0, "oor read @1023");

        // clken low blocks the new accept but the pipeline drains
        set_p(1, 1'b1, 1'b0, 10'd5, '0, '0);
        step();
        a1.clken = 1'b0;
        chk("clken drain valid", 32'(a1.readdatavalid), 32'd1);
        chk("clken drain data", a1.readdata, 32'hDEADBEEF);
        step();
        idle();
        a1.clken = 1'b1;
        chk("clken blocked valid", 32'(a1.readdatavalid), 32'd0);
        step();

        // Back-to-back reads with reset pulsed after the second accept
        for (int i = 0; i < 2; i++) begin
            set_p(1, 1'b1, 1'b0, AW'(i), '0, '0);
            step();
        end
        reset = 1'b1;
        exp_q.delete();
        s2_turn = 1'b0;
        for (int ch = 0; ch < 4; ch++) last_d[ch] = '0;
        idle();
        #1;
        chk("reset mid-read valid dut0", 32'(a1.readdatavalid), 32'd0);
        chk("reset mid-read valid dut1", 32'(b1.readdatavalid), 32'd0);
        chk("reset mid-read data dut0", a1.readdata, 32'd0);
        chk("reset mid-read data dut1", b1.readdata, 32'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            set_p(1, 1'b1, 1'b0, AW'(i), '0, '0);
            step();
        end
        idle();
        repeat (3) step();
        rd_lit(1, 10'd0, 32'hA0A0A000, "post-reset @0");
        rd_lit(2, 10'd3, 32'hA0A0A003, "post-reset @3");
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onchip_dpram_arb.md
Name: onchip_dpram_arb

Overview:
- Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) sharing one clock.
- Next generation of the fixed 2048x32 dual-port SRAM: width, depth, init file and output register are configurable.
- Adds pipelined reads with readdatavalid, same-address write-collision arbitration with fair priority rotation, and mixed-port read-during-write forwarding (new data).
- Sits between the Nios system interconnect and a shared data buffer.

Parameters:
DATA_WIDTH, 32, data bits per word; multiple of 8
ADDR_WIDTH, 11, word address bits
DEPTH, 2048, number of words; must be ≤ 2**ADDR_WIDTH
OUTPUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1)
INIT_FILE, "onchip_dpram_arb.hex", initial memory contents; no file means contents undefined

Ports:
clk  in  1  single clock for both ports
reset  in  1  asynchronous, active-high reset
reset_req  in  1  when high, blocks all accesses on both ports
clken  in  1  s1 clock enable; gates acceptance only
chipselect  in  1  s1 select
read  in  1  s1 read request
write  in  1  s1 write request
address  in  ADDR_WIDTH  s1 word address
byteenable  in  DATA_WIDTH/8  s1 byte lanes
writedata  in  DATA_WIDTH  s1 write data
waitrequest  out  1  s1 stall
readdata  out  DATA_WIDTH  s1 read data
readdatavalid  out  1  s1 read data strobe
clken2, chipselect2, read2, write2, address2, byteenable2, writedata2  in  (widths as s1)  s2 equivalents
waitrequest2, readdata2, readdatavalid2  out  (widths as s1)  s2 equivalents

Behaviour:
- Reset (asynchronous): readdata/readdata2 = 0; readdatavalid/readdatavalid2 = 0; all pipeline valid bits = 0; prio_b = 0. Memory contents are preserved. In-flight reads are dropped with no valid strobe.
- Request on port p: chipselect & (read | write) & clken. If read and write are both high, it is a write and produces no readdatavalid.
- Accept on port p: request & ~waitrequest_p. Unaccepted requests must be held by the master.
- Collision: both ports request writes to the same address in the same cycle.
  - prio_b = 0: s1 wins; waitrequest2 = 1.
  - prio_b = 1: s2 wins; waitrequest = 1.
  - The loser stalls exactly one cycle.
- prio_b update: after a collision the winner gets lower priority next cycle (prio_b <= ~prio_b). prio_b holds otherwise, so neither port can be stalled two consecutive cycles.
- waitrequest = reset_req | (collision & prio_b). waitrequest2 = reset_req | (collision & ~prio_b). Both are combinational.
- Writes to different addresses, or read vs. write, never stall.
- Write: only lanes with byteenable high are updated, at the clk edge of acceptance.
- Out-of-range address (≥ DEPTH): writes are ignored; reads return 0 and still strobe readdatavalid.
- Read latency: readdatavalid asserts exactly 1 + OUTPUT_REG cycles after the accept edge, for one cycle per accepted read. Back-to-back reads give a one-per-cycle valid stream.
- readdata holds its last value when readdatavalid is low.
- Mixed-port read-during-write: if port X reads the address port Y writes in the same accepted cycle, X returns the merged new data (Y's enabled lanes new, other lanes old).
- clken low blocks new accepts on that port only; the read pipeline keeps draining. clken does not affect waitrequest.
- reset_req asserted mid-read: already-accepted reads still complete.

Test Plan:
- Write 0xDEADBEEF @5 via s1 (be=1111), then s2 reads @5 → readdatavalid2 one cycle later (OUTPUT_REG=0), readdata2 = 0xDEADBEEF; with OUTPUT_REG=1, two cycles later.
- s1 writes 0xAAAAAAAA @9 with be=0011 over existing 0x12345678 → subsequent read = 0x1234AAAA.
- Both ports write @3 in the same cycle after reset: s1 data 0x11, s2 data 0x22.
  - Cycle 0: waitrequest2 = 1 and s1 commits.
  - Cycle 1: s2 commits; read @3 = 0x22.
  - Repeat the collision: waitrequest = 1 instead (rotation).
- s1 writes 0xCAFEF00D @7 while s2 reads @7 in the same cycle → readdata2 = 0xCAFEF00D.
- 4 back-to-back s1 reads, with reset pulsed after the 2nd accept → only pre-reset valids seen; readdatavalid = 0 immediately on reset; memory @0..3 unchanged afterward.
- reset_req = 1 with chipselect/write high → waitrequest = waitrequest2 = 1 and memory unchanged. Read @DEPTH (DEPTH=1000, ADDR_WIDTH=10) → readdata = 0 with valid.
